// File: rtl/data_parser_qformat_stream.sv
// Keypad key codes to NUM/OP/paren/control tokens. NUM is two's-complement Q(INT_BITS).(FRAC_BITS).
// The decimal fraction is converted by a restoring divider. Define FRAC_ROUND_EN to round half up instead of truncating.
module data_parser_qformat_stream #(
  parameter int INT_BITS        = 16,
  parameter int FRAC_BITS       = 8,
  parameter int MAX_FRAC_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4:0]                    key_code,
  input  logic                          key_valid,
  output logic                          key_ready,
  output logic                          tok_valid,
  input  logic                          tok_ready,
  output logic [2:0]                    tok_type,
  output logic [INT_BITS+FRAC_BITS-1:0] tok_value,
  output logic [3:0]                    tok_op,
  output logic [1:0]                    tok_prec,
  output logic                          tok_ovf
);
  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam int W   = INT_BITS + FRAC_BITS;
  localparam int PW  = $clog2(pow10(MAX_FRAC_DIGITS) + 1);
  localparam int RW  = PW + 1;
  localparam int AW  = INT_BITS + 4;
`ifdef FRAC_ROUND_EN
  localparam int ITERS = FRAC_BITS + 1;
`else
  localparam int ITERS = FRAC_BITS;
`endif
  localparam int CW  = $clog2(ITERS + 1);
  localparam int FDW = $clog2(MAX_FRAC_DIGITS + 1);
  localparam logic [AW-1:0] ACC_MAX = AW'((1 << (INT_BITS-1)) - 1);

  typedef enum logic [2:0] {S_IDLE, S_INT, S_FRAC, S_CONV, S_EMIT_NUM, S_EMIT_KEY} state_t;
  state_t state, state_d;

  logic [AW-1:0]  acc;
  logic [PW-1:0]  frac, p10;
  logic [RW-1:0]  r;
  logic [FRAC_BITS-1:0] q;
  logic [FDW-1:0] fdig;
  logic [CW-1:0]  cnt;
  logic           neg, sat;
  logic [4:0]     pend;

  logic is_digit, is_dot, is_neg, is_clr, is_tok, accept, last, ge;
  logic [AW-1:0] acc_nxt;
  logic [PW-1:0] frac_nxt, p10_nxt;
  logic [RW-1:0] r2, rn;
  logic [W-1:0]  mag, num_value;
  logic [2:0]    ptype;
  logic [1:0]    pprec;

  assign is_digit = key_code <= 5'd9;
  assign is_dot   = key_code == 5'd25;
  assign is_neg   = key_code == 5'd23;
  assign is_clr   = key_code == 5'd27;
  assign is_tok   = (key_code >= 5'd10 && key_code <= 5'd22) || key_code == 5'd24 ||
                    (key_code >= 5'd26 && key_code <= 5'd28);
  assign accept   = key_valid && key_ready;

  assign acc_nxt  = acc * AW'(10) + AW'(key_code);
  assign frac_nxt = frac * PW'(10) + PW'(key_code);
  assign p10_nxt  = p10 * PW'(10);

  // One restoring-division step: remainder stays below p10 throughout.
  assign r2   = r << 1;
  assign ge   = r2 >= RW'(p10);
  assign rn   = ge ? r2 - RW'(p10) : r2;
  assign last = cnt == CW'(ITERS - 1);

`ifdef FRAC_ROUND_EN
  logic [FRAC_BITS:0] q_rnd;
  assign q_rnd = {1'b0, q} + (FRAC_BITS+1)'(ge);
`endif

  assign mag       = sat ? {ACC_MAX[INT_BITS-1:0], {FRAC_BITS{1'b1}}} : {acc[INT_BITS-1:0], q};
  assign num_value = neg ? W'(-mag) : mag;

  always_comb begin
    case (pend)
      5'd21:   ptype = 3'd2;
      5'd22:   ptype = 3'd3;
      5'd26:   ptype = 3'd4;
      5'd27:   ptype = 3'd5;
      5'd28:   ptype = 3'd6;
      default: ptype = 3'd1;
    endcase
    case (pend)
      5'd10, 5'd11:                                   pprec = 2'd1;
      5'd12, 5'd13:                                   pprec = 2'd2;
      5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd24:       pprec = 2'd3;
      default:                                        pprec = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;

  always_comb begin
    state_d   = state;
    key_ready = 1'b0;
    tok_valid = 1'b0;
    tok_type  = '0;
    tok_value = '0;
    tok_op    = '0;
    tok_prec  = '0;
    tok_ovf   = 1'b0;
    case (state)
      S_IDLE: begin
        key_ready = 1'b1;
        if (accept) begin
          if (is_digit)    state_d = S_INT;
          else if (is_dot) state_d = S_FRAC;
          else if (is_tok) state_d = S_EMIT_KEY;
        end
      end
      S_INT, S_FRAC: begin
        key_ready = 1'b1;
        if (accept) begin
          if (is_dot)      state_d = S_FRAC;
          else if (is_clr) state_d = S_EMIT_KEY;
          else if (is_tok) state_d = (fdig != '0) ? S_CONV : S_EMIT_NUM;
        end
      end
      S_CONV: if (last) state_d = S_EMIT_NUM;
      S_EMIT_NUM: begin
        tok_valid = 1'b1;
        tok_value = num_value;
        tok_ovf   = sat;
        if (tok_ready) state_d = S_EMIT_KEY;
      end
      S_EMIT_KEY: begin
        tok_valid = 1'b1;
        tok_type  = ptype;
        if (ptype == 3'd1) begin
          tok_op   = 4'(pend - 5'd10);
          tok_prec = pprec;
        end
        if (tok_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; frac <= '0; p10 <= PW'(1); r <= '0; q <= '0;
      fdig <= '0; cnt <= '0; neg <= 1'b0; sat <= 1'b0; pend <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (is_digit)    acc <= AW'(key_code);
          else if (is_neg) neg <= ~neg;
          else if (is_tok) begin
            pend <= key_code;
            if (is_clr) neg <= 1'b0;
          end
        end
        S_INT, S_FRAC: if (accept) begin
          if (is_digit) begin
            if (state == S_INT) begin
              // Once past the positive limit the integer part freezes; output saturates.
              if (!sat) begin
                if (acc_nxt > ACC_MAX) sat <= 1'b1;
                else                   acc <= acc_nxt;
              end
            end else if (fdig < FDW'(MAX_FRAC_DIGITS)) begin
              frac <= frac_nxt;
              p10  <= p10_nxt;
              fdig <= fdig + 1'b1;
            end
          end else if (is_clr) begin
            acc <= '0; frac <= '0; p10 <= PW'(1); fdig <= '0;
            neg <= 1'b0; sat <= 1'b0; pend <= key_code;
          end else if (is_tok) begin
            pend <= key_code;
            r    <= RW'(frac);
            q    <= '0;
            cnt  <= '0;
          end
        end
        S_CONV: begin
          cnt <= cnt + 1'b1;
          r   <= rn;
`ifdef FRAC_ROUND_EN
          // Guard iteration: add the next quotient bit; a carry bumps the integer part.
          if (last) begin
            q <= q_rnd[FRAC_BITS-1:0];
            if (q_rnd[FRAC_BITS]) begin
              if (acc >= ACC_MAX) sat <= 1'b1;
              else                acc <= acc + 1'b1;
            end
          end else
            q <= (q << 1) | FRAC_BITS'(ge);
`else
          q <= (q << 1) | FRAC_BITS'(ge);
`endif
        end
        S_EMIT_NUM: if (tok_ready) begin
          acc <= '0; frac <= '0; p10 <= PW'(1); fdig <= '0; q <= '0;
          neg <= 1'b0; sat <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_data_parser_qformat_stream.sv
// Scoreboard bench for data_parser_qformat_stream: directed cases plus randomized key streams
// against an integer-arithmetic model of the token rules.
module tb_data_parser_qformat_stream;
  localparam int IB = 16, FB = 8, MFD = 4, W = IB + FB;
`ifdef FRAC_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam longint MAXI   = (longint'(1) << (IB-1)) - 1;
  localparam longint MAXMAG = (longint'(1) << (W-1)) - 1;
  localparam longint MASK   = (longint'(1) << W) - 1;

  logic clk = 0, rst_n = 0;
  logic [4:0] key_code = '0;
  logic key_valid = 0, key_ready, tok_valid, tok_ready = 0, tok_ovf;
  logic [2:0] tok_type;
  logic [W-1:0] tok_value;
  logic [3:0] tok_op;
  logic [1:0] tok_prec;

  always #5 clk = ~clk;

  data_parser_qformat_stream #(.INT_BITS(IB), .FRAC_BITS(FB), .MAX_FRAC_DIGITS(MFD)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type), .tok_value(tok_value),
    .tok_op(tok_op), .tok_prec(tok_prec), .tok_ovf(tok_ovf));

  typedef struct {int typ; longint val; int op; int prec; int ovf;} tok_t;
  tok_t exp_q[$];
  int checks = 0, passes = 0, cyc = 0, last_acc_cyc = 0, rdy_mode = 1, ntok = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
  endtask

  // Reference model: numbers accumulated as plain integers, converted at the end.
  bit m_in, m_dot, m_sat, m_neg;
  longint m_acc, m_frac, m_p10, m_fdig;

  task automatic clear_num();
    m_in = 0; m_dot = 0; m_sat = 0; m_acc = 0; m_frac = 0; m_p10 = 1; m_fdig = 0;
  endtask

  function automatic int prec_of(input int k);
    if (k == 10 || k == 11) return 1;
    if (k == 12 || k == 13) return 2;
    if ((k >= 14 && k <= 18) || k == 24) return 3;
    return 0;
  endfunction

  task automatic push_key_tok(input int k);
    tok_t t;
    t.typ = (k == 21) ? 2 : (k == 22) ? 3 : (k == 26) ? 4 : (k == 27) ? 5 : (k == 28) ? 6 : 1;
    t.op = (t.typ == 1) ? k - 10 : 0;
    t.prec = (t.typ == 1) ? prec_of(k) : 0;
    t.val = 0; t.ovf = 0;
    exp_q.push_back(t);
  endtask

  task automatic push_num();
    tok_t t;
    longint qf, mag;
    qf = 0;
    if (m_fdig > 0) begin
      if (RND != 0) qf = (((m_frac << (FB+1)) / m_p10) + 1) >> 1;
      else          qf = (m_frac << FB) / m_p10;
    end
    mag = (m_acc << FB) + qf;
    t.ovf = (m_sat || mag > MAXMAG) ? 1 : 0;
    if (t.ovf != 0) mag = MAXMAG;
    t.val = (m_neg ? -mag : mag) & MASK;
    t.typ = 0; t.op = 0; t.prec = 0;
    exp_q.push_back(t);
  endtask

  task automatic model_key(input int k);
    if (k <= 9) begin
      if (!m_in) begin m_in = 1; m_dot = 0; m_acc = k; end
      else if (!m_dot) begin
        if (!m_sat) begin
          if (m_acc * 10 + k > MAXI) m_sat = 1;
          else m_acc = m_acc * 10 + k;
        end
      end else if (m_fdig < MFD) begin
        m_frac = m_frac * 10 + k; m_p10 = m_p10 * 10; m_fdig++;
      end
    end else if (k == 25) begin
      if (!m_in) begin m_in = 1; m_acc = 0; end
      m_dot = 1;
    end else if (k == 23) begin
      if (!m_in) m_neg = !m_neg;
    end else if (k == 27) begin
      push_key_tok(k); clear_num(); m_neg = 0;
    end else begin
      if (m_in) begin push_num(); clear_num(); m_neg = 0; end
      push_key_tok(k);
    end
  endtask

  task automatic send_key(input int k);
    bit done;
    done = 0;
    @(negedge clk);
    key_code = 5'(k); key_valid = 1;
    for (int n = 0; n < 500 && !done; n++) begin
      if (key_ready) begin @(posedge clk); model_key(k); done = 1; end
      else @(negedge clk);
    end
    if (!done) chk("key_accept_timeout", 0, 1);
    @(negedge clk);
    key_valid = 0;
    last_acc_cyc = cyc;
  endtask

  task automatic send_keys(input int ks[$]);
    foreach (ks[i]) send_key(ks[i]);
  endtask

  // Latency in edges after the terminator's accepting edge until tok_valid shows.
  task automatic check_latency(input string nm, input int expv);
    int n;
    n = 0;
    while (!tok_valid && n < 100) begin @(negedge clk); n++; end
    chk(nm, cyc - last_acc_cyc, expv);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tok_valid) && n < 500) begin @(negedge clk); n++; end
    chk(nm, exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0)      tok_ready = 0;
    else if (rdy_mode == 1) tok_ready = 1;
    else                    tok_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on each transfer, checks outputs hold while stalled.
  initial begin
    tok_t e;
    logic [33:0] held;
    bit stalled;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (rst_n && tok_valid) begin
        if (stalled) chk("stall_stable", {tok_type, tok_value, tok_op, tok_prec, tok_ovf}, held);
        if (tok_ready) begin
          stalled = 0;
          if (exp_q.size() == 0) chk("unexpected_token", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk($sformatf("tok%0d_type", ntok), tok_type, e.typ);
            chk($sformatf("tok%0d_value", ntok), tok_value, e.val);
            chk($sformatf("tok%0d_op", ntok), tok_op, e.op);
            chk($sformatf("tok%0d_prec", ntok), tok_prec, e.prec);
            chk($sformatf("tok%0d_ovf", ntok), tok_ovf, e.ovf);
          end
          ntok++;
        end else begin
          stalled = 1;
          held = {tok_type, tok_value, tok_op, tok_prec, tok_ovf};
        end
      end else stalled = 0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int seen, r, k;
    int others[$] = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 22, 24, 26, 27, 28};
    clear_num(); m_neg = 0;
    #12;
    chk("rst_key_ready", key_ready, 1);
    chk("rst_tok_valid", tok_valid, 0);
    chk("rst_tok_value", tok_value, 0);
    chk("rst_tok_type", tok_type, 0);
    chk("rst_tok_ovf", tok_ovf, 0);
    @(negedge clk); rst_n = 1;

    rdy_mode = 1;
    send_keys('{1, 2, 25, 5, 10});
    check_latency("lat_frac_num", FB + RND);
    drain("drain_12_5");
    send_keys('{0, 25, 1, 26});
    check_latency("lat_point1", FB + RND);
    drain("drain_0_1");
    send_keys('{4, 0, 0, 0, 0, 12});
    check_latency("lat_int_num", 0);
    drain("drain_sat");
    send_keys('{23, 3, 26});
    drain("drain_neg3");
    send_keys('{23, 23, 3, 26});
    drain("drain_negneg3");

    // Consumer stalls on a NUM; a key offered meanwhile must not be taken.
    rdy_mode = 0;
    send_keys('{3, 26});
    for (int i = 0; i < 5; i++) begin
      key_code = 5'd7; key_valid = 1;
      chk("stall_tok_valid", tok_valid, 1);
      chk("stall_key_ready", key_ready, 0);
      chk("stall_value", tok_value, 'h300);
      @(negedge clk);
    end
    key_valid = 0;
    rdy_mode = 1;
    drain("drain_stall");

    send_keys('{7, 25, 2, 5, 27});
    drain("drain_clr");

    // Abort during the fraction conversion.
    send_keys('{7, 25, 2, 5, 10});
    @(negedge clk); @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_tok_valid", tok_valid, 0);
    exp_q.delete(); clear_num(); m_neg = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("abort_key_ready", key_ready, 1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (tok_valid) seen++;
      @(negedge clk);
    end
    chk("abort_no_token", seen, 0);

    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      k = $urandom_range(0, 9);
      else if (r < 65) k = 25;
      else if (r < 70) k = 23;
      else             k = others[$urandom_range(0, others.size() - 1)];
      send_key(k);
    end
    send_key(26);
    drain("drain_random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
